// File: rtl/pipe_stage_reg_if.sv
// Handshake bundle for pipe_stage_reg: upstream valid/ready/data, flush,
// downstream valid/ready/data and the stall counter.
interface pipe_stage_reg_if #(
  parameter int DATA_W = 76,
  parameter int CNT_W  = 16
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [CNT_W-1:0]  stall_cnt;

  modport master (
    output in_valid, in_data, flush, out_ready,
    input  in_ready, out_valid, out_data, stall_cnt
  );

  modport slave (
    input  in_valid, in_data, flush, out_ready,
    output in_ready, out_valid, out_data, stall_cnt
  );
endinterface

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline register with flush and saturating stall counter.
// Define PIPE_STAGE_SKID_EN for a second (skid) entry and a registered-path in_ready.
module pipe_stage_reg #(
  parameter int DATA_W = 76,
  parameter int CNT_W  = 16
) (
  input logic             clk,
  input logic             reset,
  pipe_stage_reg_if.slave bus
);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic              out_valid_r;
  logic [DATA_W-1:0] out_data_r;
  logic [CNT_W-1:0]  stall_cnt_r;
  logic              in_ready_s;
  logic              in_fire_s;
  logic              out_fire_s;
  logic              out_valid_nxt_s;
  logic [DATA_W-1:0] out_data_nxt_s;

  assign in_fire_s  = bus.in_valid & in_ready_s;
  assign out_fire_s = out_valid_r & bus.out_ready;

`ifdef PIPE_STAGE_SKID_EN
  logic              skid_valid_r;
  logic [DATA_W-1:0] skid_data_r;
  logic              skid_valid_nxt_s;
  logic [DATA_W-1:0] skid_data_nxt_s;

  // Acceptance depends only on skid occupancy, never on out_ready.
  always_comb begin
    in_ready_s = !reset && !bus.flush && !skid_valid_r;
  end

  // Next state for the output and skid entries.
  always_comb begin
    out_valid_nxt_s  = out_valid_r;
    out_data_nxt_s   = out_data_r;
    skid_valid_nxt_s = skid_valid_r;
    skid_data_nxt_s  = skid_data_r;
    if (bus.flush) begin
      out_valid_nxt_s  = 1'b0;
      skid_valid_nxt_s = 1'b0;
    end else if (!out_valid_r || out_fire_s) begin
      // Output slot frees up: the older skid entry has priority over new input.
      if (skid_valid_r) begin
        out_valid_nxt_s  = 1'b1;
        out_data_nxt_s   = skid_data_r;
        skid_valid_nxt_s = 1'b0;
      end else if (in_fire_s) begin
        out_valid_nxt_s = 1'b1;
        out_data_nxt_s  = bus.in_data;
      end else begin
        out_valid_nxt_s = 1'b0;
      end
    end else if (in_fire_s) begin
      skid_valid_nxt_s = 1'b1;
      skid_data_nxt_s  = bus.in_data;
    end else begin
      skid_valid_nxt_s = skid_valid_r;
    end
  end

  // Skid entry storage.
  always_ff @(posedge clk) begin
    if (reset) begin
      skid_valid_r <= 1'b0;
      skid_data_r  <= {DATA_W{1'b0}};
    end else begin
      skid_valid_r <= skid_valid_nxt_s;
      skid_data_r  <= skid_data_nxt_s;
    end
  end
`else
  // Single entry: accept when empty or when the held entry leaves this cycle.
  always_comb begin
    in_ready_s = !reset && !bus.flush && (!out_valid_r || bus.out_ready);
  end

  // Next state for the single output entry.
  always_comb begin
    out_valid_nxt_s = out_valid_r;
    out_data_nxt_s  = out_data_r;
    if (bus.flush) begin
      out_valid_nxt_s = 1'b0;
    end else if (in_fire_s) begin
      out_valid_nxt_s = 1'b1;
      out_data_nxt_s  = bus.in_data;
    end else if (out_fire_s) begin
      out_valid_nxt_s = 1'b0;
    end else begin
      out_valid_nxt_s = out_valid_r;
    end
  end
`endif

  // Output entry and saturating stall counter; flush leaves the counter alone.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_r <= 1'b0;
      out_data_r  <= {DATA_W{1'b0}};
      stall_cnt_r <= {CNT_W{1'b0}};
    end else begin
      out_valid_r <= out_valid_nxt_s;
      out_data_r  <= out_data_nxt_s;
      if (out_valid_r && !bus.out_ready && (stall_cnt_r != CNT_MAX)) begin
        stall_cnt_r <= stall_cnt_r + CNT_ONE;
      end else begin
        stall_cnt_r <= stall_cnt_r;
      end
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = out_valid_r;
  assign bus.out_data  = out_data_r;
  assign bus.stall_cnt = stall_cnt_r;
endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: directed scenarios plus random
// traffic compared against a queue-based reference model.
module tb_pipe_stage_reg;
  localparam int DW = 76;
  localparam int CW = 4;
`ifdef PIPE_STAGE_SKID_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  logic [DW-1:0] mq[$];
  logic [DW-1:0] m_od;
  int            m_stall;

  pipe_stage_reg_if #(.DATA_W(DW), .CNT_W(CW)) bus ();

  pipe_stage_reg #(.DATA_W(DW), .CNT_W(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] rand_data();
    logic [95:0] w;
    w = {$urandom, $urandom, $urandom};
    return w[DW-1:0];
  endfunction

  // One clock: drive inputs, check in_ready before the edge, advance model, check outputs.
  task automatic cycle(input bit rst, input bit iv, input logic [DW-1:0] id,
                       input bit fl, input bit ordy);
    bit exp_rdy;
    bit in_fire;
    bit out_fire;
    reset         = rst;
    bus.in_valid  = iv;
    bus.in_data   = id;
    bus.flush     = fl;
    bus.out_ready = ordy;
    if (rst || fl) exp_rdy = 1'b0;
    else if (CAP == 2) exp_rdy = (mq.size() < 2);
    else exp_rdy = (mq.size() == 0) || ordy;
    @(negedge clk);
    chk("in_ready", {{(DW-1){1'b0}}, bus.in_ready}, {{(DW-1){1'b0}}, exp_rdy});
    @(posedge clk);
    if (rst) begin
      mq.delete();
      m_od    = '0;
      m_stall = 0;
    end else begin
      in_fire  = iv && exp_rdy;
      out_fire = (mq.size() > 0) && ordy;
      if ((mq.size() > 0) && !ordy && (m_stall < (2**CW - 1))) m_stall++;
      if (out_fire) void'(mq.pop_front());
      if (fl) mq.delete();
      else if (in_fire) mq.push_back(id);
      if (mq.size() > 0) m_od = mq[0];
    end
    #1;
    chk("out_valid", {{(DW-1){1'b0}}, bus.out_valid}, {{(DW-1){1'b0}}, (mq.size() > 0)});
    chk("out_data", bus.out_data, m_od);
    chk("stall_cnt", {{(DW-CW){1'b0}}, bus.stall_cnt}, DW'(m_stall));
  endtask

  initial begin
    checks = 0;
    errors = 0;
    m_od = '0;
    m_stall = 0;
    reset = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.flush = 1'b0;
    bus.out_ready = 1'b0;
    @(posedge clk);
    #1;

    // Reset with input offered: nothing accepted, outputs cleared.
    cycle(1'b1, 1'b1, 76'h5, 1'b0, 1'b1);
    cycle(1'b1, 1'b1, 76'h6, 1'b0, 1'b1);
    chk("reset_od", bus.out_data, 76'h0);

    // Stream 1..8 with out_ready high.
    for (int i = 1; i <= 8; i++) cycle(1'b0, 1'b1, DW'(i), 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 76'h0, 1'b0, 1'b1);
    chk("stream_stall", {{(DW-CW){1'b0}}, bus.stall_cnt}, 76'h0);

    // Hold 0xAA for 5 stalled cycles, then release.
    cycle(1'b0, 1'b1, 76'hAA, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 76'h0, 1'b0, 1'b0);
    chk("hold_od", bus.out_data, 76'hAA);
    chk("hold_stall", {{(DW-CW){1'b0}}, bus.stall_cnt}, 76'h5);
    cycle(1'b0, 1'b0, 76'h0, 1'b0, 1'b1);
    chk("hold_done", {{(DW-1){1'b0}}, bus.out_valid}, 76'h0);

    // Skid fill / single-entry backpressure.
    cycle(1'b1, 1'b0, 76'h0, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 76'h11, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 76'h22, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 76'h0, 1'b0, 1'b1);
    cycle(1'b0, 1'b1, 76'h22, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 76'h0, 1'b0, 1'b1);

    // Flush with entries held and input offered in the flush cycle.
    cycle(1'b0, 1'b1, 76'h31, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 76'h32, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 76'h33, 1'b1, 1'b0);
    chk("flush_ov", {{(DW-1){1'b0}}, bus.out_valid}, 76'h0);
    cycle(1'b0, 1'b0, 76'h0, 1'b0, 1'b1);

    // Reset in the middle of a stall.
    cycle(1'b1, 1'b0, 76'h0, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 76'h44, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 76'h0, 1'b0, 1'b0);
    chk("mid_stall3", {{(DW-CW){1'b0}}, bus.stall_cnt}, 76'h3);
    cycle(1'b1, 1'b1, 76'h45, 1'b0, 1'b0);
    chk("mid_rst_od", bus.out_data, 76'h0);
    cycle(1'b0, 1'b0, 76'h0, 1'b0, 1'b0);

    // Saturation: 15 stall cycles then 3 more.
    cycle(1'b0, 1'b1, 76'h55, 1'b0, 1'b0);
    for (int i = 0; i < 18; i++) cycle(1'b0, 1'b0, 76'h0, 1'b0, 1'b0);
    chk("sat_stall", {{(DW-CW){1'b0}}, bus.stall_cnt}, 76'hF);
    cycle(1'b1, 1'b0, 76'h0, 1'b0, 1'b0);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 63) == 0), ($urandom_range(0, 3) != 0), rand_data(),
            ($urandom_range(0, 15) == 0), ($urandom_range(0, 2) != 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
